// File: rtl/serial_pattern_detector_if.sv
// Serial detector bundle: per-cycle bit input with control, plus match/status outputs.
// The master side drives the stream; the slave side is the detector.
interface serial_pattern_detector_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             din;
    logic             clr;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             armed;

    modport master (
        output en, din, clr,
        input  match, match_count, armed
    );

    modport slave (
        input  en, din, clr,
        output match, match_count, armed
    );
endinterface

// File: rtl/serial_pattern_detector.sv
// Purpose: detect a PAT_W-bit pattern (MSB first) in a serial stream; pulse match, count matches.
// Latency: match is registered, high the cycle after the completing sample edge.
// Backpressure: none; en qualifies din each cycle and the block always accepts.
module serial_pattern_detector #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8,
    parameter int               OVERLAP = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_pattern_detector_if.slave bus
);
    localparam int               FILL_W  = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              match_q, match_d;

    logic [PAT_W-1:0]  next_hist;
    logic [FILL_W-1:0] next_fill;
    logic              hit;

    always_comb begin
        next_hist = {hist_q, bus.din};
        next_fill = (fill_q == FULL) ? FULL : fill_q + 1'b1;
        hit       = bus.en && (next_hist == PATTERN) && (next_fill == FULL);

        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;

        if (bus.clr) begin
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (bus.en) begin
            hist_d  = next_hist[PAT_W-2:0];
            // Non-overlapping mode forgets the matched bits by emptying the fill count.
            fill_d  = (hit && OVERLAP == 0) ? '0 : next_fill;
            match_d = hit;
            if (hit && cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
        end
    end

    assign bus.match       = match_q;
    assign bus.match_count = cnt_q;
    assign bus.armed       = (fill_q == FULL);
endmodule
